// File: rtl/dma_controller_pkg.sv
// Shared definitions for the line-based DMA controller: bus widths,
// default line geometry and the controller state encoding.
package dma_controller_pkg;

    localparam int WORD_SIZE          = 16;
    localparam int LINE_SIZE          = 64;
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int LAT_WIDTH          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_WRITE,
        ST_RELEASE
    } dma_state_t;

endpackage

// File: rtl/dma_latency_counter.sv
// Write-latency counter: loads a start value, counts up while enabled and
// flags the terminal count so the controller knows the last write cycle.
module dma_latency_counter
    import dma_controller_pkg::*;
#(
    parameter int TERMINAL = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] load_value,
    input  logic                 enable,
    output logic                 tc
);

    localparam logic [LAT_WIDTH-1:0] TC_VALUE = TERMINAL[LAT_WIDTH-1:0];

    logic [LAT_WIDTH-1:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (load) begin
            lat_cnt <= load_value;
        end else if (enable) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    assign tc = (lat_cnt == TC_VALUE);

endmodule

// File: rtl/dma_controller.sv
// Line-based DMA controller: requests the bus, pulls 64-bit lines from a
// device and writes each one to memory, holding the strobe MEM_LATENCY cycles.
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int LINE_WORDS  = DEFAULT_LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic [WORD_SIZE-1:0] cmd_length,
    output logic                 cmd_ready,
    output logic                 BR,
    input  logic                 BG,
    input  logic                 dev_valid,
    input  logic [LINE_SIZE-1:0] dev_data,
    output logic                 dev_ready,
    output logic [WORD_SIZE-1:0] m_address,
    output logic                 m_writeM,
    output logic [LINE_SIZE-1:0] m_data,
    output logic                 busy,
    output logic                 interrupt
);

    localparam int LINE_SHIFT = $clog2(LINE_WORDS);
    localparam logic [WORD_SIZE-1:0] ADDR_STEP = WORD_SIZE'(LINE_WORDS);

    dma_state_t           state;
    logic [WORD_SIZE-1:0] addr_reg;
    logic [WORD_SIZE-1:0] lines_left;
    logic [LINE_SIZE-1:0] line_reg;
    logic                 line_held;
    logic [WORD_SIZE-1:0] cmd_lines;
    logic                 write_active;
    logic                 lat_load;
    logic                 lat_tc;

    assign cmd_lines    = cmd_length >> LINE_SHIFT;
    assign write_active = (state == ST_WRITE) && BG;
    assign lat_load     = !write_active || lat_tc;

    dma_latency_counter #(
        .TERMINAL(MEM_LATENCY - 1)
    ) u_lat_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (lat_load),
        .load_value('0),
        .enable    (write_active),
        .tc        (lat_tc)
    );

    // line_held keeps an aborted line so the re-grant rewrites it instead of re-fetching.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_reg   <= '0;
            lines_left <= '0;
            line_reg   <= '0;
            line_held  <= 1'b0;
            interrupt  <= 1'b0;
        end else begin
            interrupt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_reg   <= cmd_addr;
                        lines_left <= cmd_lines;
                        state      <= (cmd_lines != '0) ? ST_REQ : ST_RELEASE;
                    end
                end
                ST_REQ: begin
                    if (BG) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!BG) begin
                        state <= ST_REQ;
                    end else if (line_held) begin
                        state <= ST_WRITE;
                    end else if (dev_valid) begin
                        line_reg  <= dev_data;
                        line_held <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!BG) begin
                        state <= ST_REQ;
                    end else if (lat_tc) begin
                        addr_reg   <= addr_reg + ADDR_STEP;
                        lines_left <= lines_left - 16'd1;
                        line_held  <= 1'b0;
                        state      <= (lines_left > 16'd1) ? ST_FETCH : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!BG) begin
                        interrupt <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign BR        = (state == ST_REQ) || (state == ST_FETCH) || (state == ST_WRITE);
    assign dev_ready = (state == ST_FETCH) && !line_held;
    assign m_writeM  = (state == ST_WRITE);
    assign m_address = m_writeM ? addr_reg : 'z;
    assign m_data    = m_writeM ? line_reg : 'z;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: vector tables for the straight-line
// transfers plus hand sequences for grant abort and mid-transfer reset.
module tb_dma_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_length;
    logic        cmd_ready;
    logic        BR;
    logic        BG;
    logic        dev_valid;
    logic [63:0] dev_data;
    logic        dev_ready;
    wire  [15:0] m_address;
    logic        m_writeM;
    wire  [63:0] m_data;
    logic        busy;
    logic        interrupt;

    int total = 0;
    int bad   = 0;

    // Flag order: {cmd_ready, BR, dev_ready, m_writeM, busy, interrupt}
    localparam logic [5:0] IDLE_F  = 6'b100000;
    localparam logic [5:0] IRQ_F   = 6'b100001;
    localparam logic [5:0] REQ_F   = 6'b010010;
    localparam logic [5:0] FETCH_F = 6'b011010;
    localparam logic [5:0] HELD_F  = 6'b010010;
    localparam logic [5:0] WRITE_F = 6'b010110;
    localparam logic [5:0] REL_F   = 6'b000010;

    localparam logic [63:0] D0 = 64'h1111_0000_AAAA_0001;
    localparam logic [63:0] D1 = 64'h2222_0000_BBBB_0002;
    localparam logic [63:0] D2 = 64'h3333_0000_CCCC_0003;
    localparam logic [63:0] DA = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] DB = 64'hFEED_FACE_89AB_CDEF;

    typedef struct packed {
        logic        cv;
        logic [15:0] addr;
        logic [15:0] len;
        logic        bg;
        logic        dv;
        logic [63:0] data;
        logic [5:0]  flags;
        logic [15:0] ea;
        logic [63:0] ed;
    } vec_t;

    vec_t vecs[$];

    dma_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_addr  (cmd_addr),
        .cmd_length(cmd_length),
        .cmd_ready (cmd_ready),
        .BR        (BR),
        .BG        (BG),
        .dev_valid (dev_valid),
        .dev_data  (dev_data),
        .dev_ready (dev_ready),
        .m_address (m_address),
        .m_writeM  (m_writeM),
        .m_data    (m_data),
        .busy      (busy),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    // Drive inputs for one cycle, then sample one time unit past the edge.
    task automatic applyStimulus(input logic rst, input logic cv, input logic [15:0] addr,
                                 input logic [15:0] len, input logic bg, input logic dv,
                                 input logic [63:0] data);
        reset      = rst;
        cmd_valid  = cv;
        cmd_addr   = addr;
        cmd_length = len;
        BG         = bg;
        dev_valid  = dv;
        dev_data   = data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] exp_flags,
                               input logic [15:0] exp_addr, input logic [63:0] exp_data);
        logic [5:0] act;
        logic       ok;
        act = {cmd_ready, BR, dev_ready, m_writeM, busy, interrupt};
        ok  = (act === exp_flags);
        if (exp_flags[2] && ((m_address !== exp_addr) || (m_data !== exp_data))) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s: got flags=%b addr=%h data=%h, expected flags=%b addr=%h data=%h",
                     name, act, m_address, m_data, exp_flags, exp_addr, exp_data);
        end
    endtask

    function automatic void add(input logic cv, input logic [15:0] addr, input logic [15:0] len,
                                input logic bg, input logic dv, input logic [63:0] data,
                                input logic [5:0] flags, input logic [15:0] ea,
                                input logic [63:0] ed);
        vec_t v;
        v.cv = cv; v.addr = addr; v.len = len; v.bg = bg; v.dv = dv; v.data = data;
        v.flags = flags; v.ea = ea; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic runTable(input string scen);
        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].cv, vecs[i].addr, vecs[i].len, vecs[i].bg,
                          vecs[i].dv, vecs[i].data);
            checkOutput($sformatf("%s[%0d]", scen, i), vecs[i].flags, vecs[i].ea, vecs[i].ed);
        end
        vecs.delete();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        doReset();
        checkOutput("reset_state", IDLE_F, 16'h0, 64'h0);

        // Three-line transfer with grant one cycle after BR.
        add(1, 16'h01F0, 16'd12, 0, 1, D0, REQ_F,   0, 0);
        add(0, 16'h0,    16'd0,  0, 1, D0, REQ_F,   0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D0, FETCH_F, 0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D0, WRITE_F, 16'h01F0, D0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, D1, WRITE_F, 16'h01F0, D0);
        add(0, 16'h0,    16'd0,  1, 1, D1, FETCH_F, 0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D1, WRITE_F, 16'h01F4, D1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, D2, WRITE_F, 16'h01F4, D1);
        add(0, 16'h0,    16'd0,  1, 1, D2, FETCH_F, 0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D2, WRITE_F, 16'h01F8, D2);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, D0, WRITE_F, 16'h01F8, D2);
        add(0, 16'h0,    16'd0,  1, 1, D0, REL_F,   0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D0, REL_F,   0, 0);
        add(0, 16'h0,    16'd0,  0, 1, D0, IRQ_F,   0, 0);
        add(0, 16'h0,    16'd0,  0, 1, D0, IDLE_F,  0, 0);
        runTable("basic");

        // Length below one line: no bus request, immediate completion.
        add(1, 16'h0040, 16'd3,  0, 0, 0, REL_F,  0, 0);
        add(0, 16'h0,    16'd0,  0, 0, 0, IRQ_F,  0, 0);
        add(0, 16'h0,    16'd0,  0, 0, 0, IDLE_F, 0, 0);
        runTable("zero_len");

        // Address wraps from the top of the space to zero.
        add(1, 16'hFFFC, 16'd8,  0, 1, D1, REQ_F,   0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D1, FETCH_F, 0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D1, WRITE_F, 16'hFFFC, D1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, D2, WRITE_F, 16'hFFFC, D1);
        add(0, 16'h0,    16'd0,  1, 1, D2, FETCH_F, 0, 0);
        add(0, 16'h0,    16'd0,  1, 1, D2, WRITE_F, 16'h0000, D2);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, D0, WRITE_F, 16'h0000, D2);
        add(0, 16'h0,    16'd0,  1, 1, D0, REL_F,   0, 0);
        add(0, 16'h0,    16'd0,  0, 1, D0, IRQ_F,   0, 0);
        runTable("wrap");

        // New commands while busy must not disturb the single-line transfer.
        add(1, 16'h0100, 16'd4,  0, 1, D2, REQ_F,   0, 0);
        add(1, 16'h5550, 16'd40, 1, 1, D2, FETCH_F, 0, 0);
        add(1, 16'h5550, 16'd40, 1, 1, D2, WRITE_F, 16'h0100, D2);
        for (int i = 0; i < 3; i++) add(1, 16'h5550, 16'd40, 1, 1, D0, WRITE_F, 16'h0100, D2);
        add(1, 16'h5550, 16'd40, 1, 1, D0, REL_F,   0, 0);
        add(1, 16'h5550, 16'd40, 0, 1, D0, IRQ_F,   0, 0);
        add(0, 16'h0,    16'd0,  0, 1, D0, IDLE_F,  0, 0);
        runTable("cmd_busy");

        // Grant withheld, then dropped in the second write cycle.
        doReset();
        applyStimulus(0, 1, 16'h0200, 16'd8, 0, 0, 64'h0);
        checkOutput("abort_accept", REQ_F, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 16'h0, 16'd0, 0, 0, 64'h0);
            checkOutput($sformatf("abort_wait[%0d]", i), REQ_F, 0, 0);
        end
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 0, 64'h0);
        checkOutput("abort_grant", FETCH_F, 0, 0);
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 1, DA);
        checkOutput("abort_wr1", WRITE_F, 16'h0200, DA);
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 0, 64'h0);
        checkOutput("abort_wr2", WRITE_F, 16'h0200, DA);
        applyStimulus(0, 0, 16'h0, 16'd0, 0, 1, DB);
        checkOutput("abort_drop", REQ_F, 0, 0);
        // The held line is not re-fetched, so dev_ready stays low on re-grant.
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 1, DB);
        checkOutput("abort_regrant", HELD_F, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 16'h0, 16'd0, 1, 1, DB);
            checkOutput($sformatf("abort_rewrite[%0d]", i), WRITE_F, 16'h0200, DA);
        end
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 0, 64'h0);
        checkOutput("abort_next_fetch", FETCH_F, 0, 0);
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 1, DB);
        checkOutput("abort_line2", WRITE_F, 16'h0204, DB);

        // Reset during the second line write abandons the transfer silently.
        doReset();
        applyStimulus(0, 1, 16'h0300, 16'd8, 1, 0, 64'h0);
        checkOutput("rst_accept", REQ_F, 0, 0);
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 0, 64'h0);
        checkOutput("rst_fetch", FETCH_F, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 16'h0, 16'd0, 1, 1, DA);
            checkOutput($sformatf("rst_line1[%0d]", i), WRITE_F, 16'h0300, DA);
        end
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 0, 64'h0);
        checkOutput("rst_fetch2", FETCH_F, 0, 0);
        applyStimulus(0, 0, 16'h0, 16'd0, 1, 1, DB);
        checkOutput("rst_line2", WRITE_F, 16'h0304, DB);
        applyStimulus(1, 0, 16'h0, 16'd0, 1, 1, DB);
        checkOutput("rst_mid_write", IDLE_F, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 16'h0, 16'd0, 0, 0, 64'h0);
            checkOutput($sformatf("rst_no_irq[%0d]", i), IDLE_F, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
